// File: rtl/arb_pkg.sv
// Shared definitions for the GHPI two-master bus arbiter.
//   arb_state_e  : arbiter FSM encoding
//   TIMEOUT_DATA : read data returned on a forced (watchdog) completion
//   TMO_CNT_W    : width of the grant watchdog counter
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
  localparam int          TMO_CNT_W    = 16;

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog for ghpi_bus_arbiter.
// Counts grant cycles that pass without a slave acknowledge and flags
// expiry on the cycle the count reaches LIMIT-1.
// Ports:
//   clk_i     : clock, rising edge
//   rst_ni    : asynchronous active-low reset
//   clear_i   : restart the count (held while the arbiter is idle)
//   inc_i     : a grant cycle without acknowledge
//   expire_o  : inc_i on the cycle the count has reached LIMIT-1
module arb_watchdog
  import arb_pkg::*;
#(
  parameter int LIMIT = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic inc_i,
  output logic expire_o
);

  logic [TMO_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (inc_i) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expire_o = inc_i && (r_cnt == TMO_CNT_W'(LIMIT - 1));

endmodule

// File: rtl/ghpi_bus_arbiter.sv
// Two-master (imem, dmem) to one-slave GHPI arbiter for von-Neumann builds.
// A grant is held for the whole transaction; ack and read data are routed
// only to the granted master. Data requests win over fetches in IDLE.
// Optional macro ARB_TIMEOUT_EN adds a grant watchdog that force-completes a
// stuck transaction with DEAD_BEEF data and sets the sticky timeout_o flag.
// Ports:
//   clk_i, rst_ni                 : clock / async active-low reset
//   imem_*                        : instruction fetch master (read only)
//   dmem_*                        : data master (load/store)
//   bus_*                         : single slave bus
//   timeout_o                     : sticky watchdog flag (0 without the macro)
module ghpi_bus_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [ADDR_W-1:0]   imem_addr_i,
  input  logic                imem_valid_i,
  output logic [DATA_W-1:0]   imem_data_o,
  output logic                imem_ack_o,
  input  logic [ADDR_W-1:0]   dmem_addr_i,
  input  logic [DATA_W-1:0]   dmem_data_i,
  output logic [DATA_W-1:0]   dmem_data_o,
  input  logic [DATA_W/8-1:0] dmem_sel_i,
  input  logic                dmem_we_i,
  input  logic                dmem_valid_i,
  output logic                dmem_ack_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_data_o,
  input  logic [DATA_W-1:0]   bus_data_i,
  output logic [DATA_W/8-1:0] bus_sel_o,
  output logic                bus_we_o,
  output logic                bus_valid_o,
  input  logic                bus_ack_i,
  output logic                timeout_o
);

  arb_state_e r_state;
  arb_state_e w_state_next;
  logic       w_expire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [DATA_W-1:0] TMO_DATA = DATA_W'(TIMEOUT_DATA);

  logic w_in_grant;
  logic r_timeout;

  assign w_in_grant = (r_state == GNT_I) || (r_state == GNT_D);

  // Counter is held clear while idle, so the first grant cycle counts 0.
  arb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (r_state == IDLE),
    .inc_i    (w_in_grant && !bus_ack_i),
    .expire_o (w_expire)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_timeout <= 1'b0;
    end else if (w_expire) begin
      r_timeout <= 1'b1;
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_expire  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    bus_addr_o   = '0;
    bus_data_o   = '0;
    bus_sel_o    = '0;
    bus_we_o     = 1'b0;
    bus_valid_o  = 1'b0;
    imem_ack_o   = 1'b0;
    imem_data_o  = '0;
    dmem_ack_o   = 1'b0;
    dmem_data_o  = '0;

    case (r_state)
      IDLE: begin
        if (dmem_valid_i) begin
          w_state_next = GNT_D;
        end else if (imem_valid_i) begin
          w_state_next = GNT_I;
        end
      end
      GNT_I: begin
        bus_addr_o  = imem_addr_i;
        bus_sel_o   = '1;
        bus_valid_o = imem_valid_i;
        imem_ack_o  = bus_ack_i && imem_valid_i;
        imem_data_o = bus_data_i;
        // Leave on handshake, or when the master withdraws (flush).
        if (!imem_valid_i || bus_ack_i) begin
          w_state_next = IDLE;
        end
      end
      GNT_D: begin
        bus_addr_o  = dmem_addr_i;
        bus_data_o  = dmem_data_i;
        bus_sel_o   = dmem_sel_i;
        bus_we_o    = dmem_we_i;
        bus_valid_o = dmem_valid_i;
        dmem_ack_o  = bus_ack_i && dmem_valid_i;
        dmem_data_o = bus_data_i;
        if (!dmem_valid_i || bus_ack_i) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

`ifdef ARB_TIMEOUT_EN
    // Forced completion: fake an ack to the granted master and withdraw
    // the request from the slave.
    if (w_expire) begin
      bus_valid_o  = 1'b0;
      w_state_next = IDLE;
      if (r_state == GNT_I) begin
        imem_ack_o  = 1'b1;
        imem_data_o = TMO_DATA;
      end else begin
        dmem_ack_o  = 1'b1;
        dmem_data_o = TMO_DATA;
      end
    end
`else
    if (w_expire) begin
      w_state_next = IDLE;
    end
`endif
  end

endmodule

// File: tb/tb_ghpi_bus_arbiter.sv
// Directed self-checking bench for ghpi_bus_arbiter (TIMEOUT_CYCLES=4).
module tb_ghpi_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] imem_addr_i;
  logic        imem_valid_i;
  logic [31:0] imem_data_o;
  logic        imem_ack_o;
  logic [31:0] dmem_addr_i;
  logic [31:0] dmem_data_i;
  logic [31:0] dmem_data_o;
  logic [3:0]  dmem_sel_i;
  logic        dmem_we_i;
  logic        dmem_valid_i;
  logic        dmem_ack_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;
  logic [3:0]  bus_sel_o;
  logic        bus_we_o;
  logic        bus_valid_o;
  logic        bus_ack_i;
  logic        timeout_o;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk_i = ~clk_i;

  ghpi_bus_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .imem_addr_i  (imem_addr_i),
    .imem_valid_i (imem_valid_i),
    .imem_data_o  (imem_data_o),
    .imem_ack_o   (imem_ack_o),
    .dmem_addr_i  (dmem_addr_i),
    .dmem_data_i  (dmem_data_i),
    .dmem_data_o  (dmem_data_o),
    .dmem_sel_i   (dmem_sel_i),
    .dmem_we_i    (dmem_we_i),
    .dmem_valid_i (dmem_valid_i),
    .dmem_ack_o   (dmem_ack_o),
    .bus_addr_o   (bus_addr_o),
    .bus_data_o   (bus_data_o),
    .bus_data_i   (bus_data_i),
    .bus_sel_o    (bus_sel_o),
    .bus_we_o     (bus_we_o),
    .bus_valid_o  (bus_valid_o),
    .bus_ack_i    (bus_ack_i),
    .timeout_o    (timeout_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %-16s obs=%0h", tag, obs);
    end else begin
      $display("FAIL %-16s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; new inputs go here.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Outputs are sampled on the falling edge.
  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    imem_valid_i = 1'b0;
    dmem_valid_i = 1'b0;
    bus_ack_i    = 1'b0;
    bus_data_i   = '0;
  endtask

  initial begin
    rst_ni       = 1'b0;
    imem_addr_i  = '0;
    dmem_addr_i  = '0;
    dmem_data_i  = '0;
    dmem_sel_i   = '0;
    dmem_we_i    = 1'b0;
    idle_inputs();

    // ---------------- reset state ----------------
    bus_ack_i = 1'b1;
    settle();
    check("rst_bus_valid", bus_valid_o, 0);
    check("rst_bus_addr",  bus_addr_o, 0);
    check("rst_dmem_ack",  dmem_ack_o, 0);
    check("rst_timeout",   timeout_o, 0);
    cyc();
    rst_ni    = 1'b1;
    bus_ack_i = 1'b0;

    // ---------------- simultaneous requests ----------------
    cyc();
    imem_addr_i  = 32'h0000_0200;
    imem_valid_i = 1'b1;
    dmem_addr_i  = 32'h0000_0100;
    dmem_data_i  = 32'h0000_AB00;
    dmem_sel_i   = 4'b0010;
    dmem_we_i    = 1'b1;
    dmem_valid_i = 1'b1;
    settle();
    check("sim_idle_valid", bus_valid_o, 0);
    cyc();                                    // GNT_D, wait cycle 1
    settle();
    check("sim_d_valid", bus_valid_o, 1);
    check("sim_d_addr",  bus_addr_o, 32'h100);
    check("sim_d_data",  bus_data_o, 32'h0000_AB00);
    check("sim_d_sel",   bus_sel_o, 4'b0010);
    check("sim_d_we",    bus_we_o, 1);
    check("sim_d_ack_w1", dmem_ack_o, 0);
    cyc();                                    // wait cycle 2
    settle();
    check("sim_d_ack_w2", dmem_ack_o, 0);
    cyc();
    bus_ack_i  = 1'b1;
    bus_data_i = 32'h0000_0055;
    settle();
    check("sim_d_ack",     dmem_ack_o, 1);
    check("sim_d_rdata",   dmem_data_o, 32'h55);
    check("sim_i_ack_off", imem_ack_o, 0);
    check("sim_i_data_off", imem_data_o, 0);
    cyc();                                    // IDLE bubble
    dmem_valid_i = 1'b0;
    settle();
    check("sim_bubble_val", bus_valid_o, 0);
    check("sim_bubble_dack", dmem_ack_o, 0);
    check("sim_bubble_iack", imem_ack_o, 0);
    cyc();                                    // GNT_I
    bus_data_i = 32'h0000_0077;
    settle();
    check("sim_i_valid", bus_valid_o, 1);
    check("sim_i_addr",  bus_addr_o, 32'h200);
    check("sim_i_sel",   bus_sel_o, 4'hF);
    check("sim_i_we",    bus_we_o, 0);
    check("sim_i_wdata", bus_data_o, 0);
    check("sim_i_ack",   imem_ack_o, 1);
    check("sim_i_rdata", imem_data_o, 32'h77);
    check("sim_i_dack",  dmem_ack_o, 0);
    check("sim_i_ddata", dmem_data_o, 0);
    cyc();
    idle_inputs();
    settle();

    // ---------------- zero-wait fetch + abandon ----------------
    cyc();                                    // cycle 1: IDLE sees valid
    imem_addr_i  = 32'h0001_0000;
    imem_valid_i = 1'b1;
    settle();
    check("zw_c1_valid", bus_valid_o, 0);
    cyc();                                    // cycle 2: GNT_I, zero wait
    bus_ack_i  = 1'b1;
    bus_data_i = 32'h0000_0013;
    settle();
    check("zw_c2_addr",  bus_addr_o, 32'h0001_0000);
    check("zw_c2_ack",   imem_ack_o, 1);
    check("zw_c2_data",  imem_data_o, 32'h13);
    cyc();                                    // cycle 3: bubble
    bus_ack_i = 1'b0;
    settle();
    check("zw_c3_valid", bus_valid_o, 0);
    check("zw_c3_ack",   imem_ack_o, 0);
    cyc();                                    // cycle 4: next grant
    settle();
    check("zw_c4_valid", bus_valid_o, 1);
    #1;
    imem_valid_i = 1'b0;                      // flush: withdraw in grant
    #1;
    check("ab_valid_drop", bus_valid_o, 0);
    check("ab_no_ack",     imem_ack_o, 0);
    cyc();
    imem_valid_i = 1'b1;                      // IDLE must not present it yet
    settle();
    check("ab_idle", bus_valid_o, 0);
    cyc();
    idle_inputs();
    settle();

    // ---------------- stray ack in IDLE ----------------
    cyc();
    bus_ack_i = 1'b1;
    settle();
    check("stray_iack", imem_ack_o, 0);
    check("stray_dack", dmem_ack_o, 0);
    cyc();
    bus_ack_i = 1'b0;

    // ---------------- stuck grant ----------------
    cyc();
    dmem_valid_i = 1'b1;
    dmem_we_i    = 1'b0;
    settle();
    for (int k = 1; k <= 3; k++) begin
      cyc();
      settle();
      check($sformatf("stk_g%0d_valid", k), bus_valid_o, 1);
      check($sformatf("stk_g%0d_ack", k), dmem_ack_o, 0);
    end
    cyc();                                    // 4th grant cycle
    settle();
`ifdef ARB_TIMEOUT_EN
    check("tmo_ack",   dmem_ack_o, 1);
    check("tmo_data",  dmem_data_o, 32'hDEAD_BEEF);
    check("tmo_valid", bus_valid_o, 0);
    check("tmo_iack",  imem_ack_o, 0);
    cyc();
    dmem_valid_i = 1'b0;
    settle();
    check("tmo_flag", timeout_o, 1);
    check("tmo_ack_pulse", dmem_ack_o, 0);
    cyc();
    cyc();
    settle();
    check("tmo_sticky", timeout_o, 1);
`else
    check("stk_g4_ack",   dmem_ack_o, 0);
    check("stk_g4_valid", bus_valid_o, 1);
    for (int k = 0; k < 4; k++) cyc();
    settle();
    check("stk_g8_valid", bus_valid_o, 1);
    check("stk_timeout",  timeout_o, 0);
    cyc();
    dmem_valid_i = 1'b0;
    settle();
`endif
    cyc();
    idle_inputs();

    // ---------------- reset mid-transaction ----------------
    cyc();
    dmem_addr_i  = 32'h0000_0300;
    dmem_valid_i = 1'b1;
    cyc();                                    // now in GNT_D
    bus_ack_i = 1'b1;
    rst_ni    = 1'b0;
    settle();
    check("rmid_dack",  dmem_ack_o, 0);
    check("rmid_valid", bus_valid_o, 0);
    check("rmid_addr",  bus_addr_o, 0);
    check("rmid_tmo",   timeout_o, 0);
    cyc();
    rst_ni       = 1'b1;
    bus_ack_i    = 1'b0;
    dmem_valid_i = 1'b0;
    imem_valid_i = 1'b1;                      // in IDLE this shows nothing
    settle();
    check("rmid_idle", bus_valid_o, 0);
    cyc();
    settle();
    check("rmid_gnt_i", bus_addr_o, 32'h0001_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ghpi_bus_arbiter.md
Name: ghpi_bus_arbiter

Overview:
Two-master to one-slave arbiter for the generic handshaking protocol interface (GHPI: valid/ack, data transfers on the cycle both are high). It sits directly downstream of the core's imem and dmem ports. It merges them onto a single memory bus for von-Neumann builds. It holds a grant for the whole transaction and returns ack and read data only to the granted master.

Parameters:
ADDR_W, 32, address width of masters and bus
DATA_W, 32, data width; byte selects are DATA_W/8 bits
TIMEOUT_CYCLES, 256, cycles in a grant state before a forced completion (used only with ARB_TIMEOUT_EN); legal range 2..65535

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
imem_addr_i  in  ADDR_W  instruction fetch address
imem_valid_i  in  1  fetch request
imem_data_o  out  DATA_W  fetch data
imem_ack_o  out  1  fetch acknowledge
dmem_addr_i  in  ADDR_W  data address
dmem_data_i  in  DATA_W  store data
dmem_data_o  out  DATA_W  load data
dmem_sel_i  in  DATA_W/8  byte selects
dmem_we_i  in  1  write strobe
dmem_valid_i  in  1  data request
dmem_ack_o  out  1  data acknowledge
bus_addr_o  out  ADDR_W  slave address
bus_data_o  out  DATA_W  slave write data
bus_data_i  in  DATA_W  slave read data
bus_sel_o  out  DATA_W/8  slave byte selects
bus_we_o  out  1  slave write strobe
bus_valid_o  out  1  slave request
bus_ack_i  in  1  slave acknowledge
timeout_o  out  1  sticky timeout flag (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE. All bus_* outputs 0, both acks 0, timeout_o 0. Reset mid-transaction abandons the transaction with no ack to either master.
- FSM states: IDLE, GNT_I, GNT_D. State is registered; bus outputs are combinational from state and the granted master's inputs.
- IDLE:
  - bus_valid_o=0; bus_addr_o, bus_data_o, bus_sel_o and bus_we_o are 0.
  - If dmem_valid_i, next state is GNT_D. Else if imem_valid_i, next state is GNT_I.
  - Fixed data priority: the core stalls fetch while a load/store is pending, so data first is deadlock-free.
- GNT_I:
  - bus_addr_o=imem_addr_i, bus_we_o=0, bus_sel_o all ones, bus_data_o=0.
  - bus_valid_o=imem_valid_i.
  - imem_ack_o=bus_ack_i & imem_valid_i.
- GNT_D:
  - bus_addr_o=dmem_addr_i, bus_data_o=dmem_data_i, bus_sel_o=dmem_sel_i, bus_we_o=dmem_we_i.
  - bus_valid_o=dmem_valid_i.
  - dmem_ack_o=bus_ack_i & dmem_valid_i.
- Leaving a grant state: on handshake (bus_valid_o & bus_ack_i), next state is IDLE. If the granted master drops valid without ack (pipeline flush), next state is also IDLE and the request is abandoned.
- The non-granted master's ack is always 0, even if bus_ack_i is high.
- Read data: imem_data_o=bus_data_i in GNT_I, else 0. dmem_data_o=bus_data_i in GNT_D, else 0.
- Latency:
  - Request appears on bus one cycle after valid is seen in IDLE.
  - Minimum transaction is 2 cycles (arbitration + zero-wait ack).
  - One IDLE bubble follows every transaction.
- bus_ack_i while in IDLE is ignored.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entry to GNT_I/GNT_D and increments each grant cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 without ack, the arbiter asserts the granted master's ack for one cycle, with its data output = 32'hDEAD_BEEF (DATA_W-truncated).
  - In that cycle bus_valid_o drops to 0, next state is IDLE, and timeout_o sets.
  - timeout_o clears only on reset.
- Undefined: no counter; a grant waits indefinitely; timeout_o is constant 0.

Decomposition:
- Shared package arb_pkg:
  - state enum (IDLE=2'd0, GNT_I=2'd1, GNT_D=2'd2)
  - TIMEOUT_DATA constant 32'hDEAD_BEEF
  - counter width constant TMO_CNT_W=16
- One natural sub-module: arb_watchdog (counter, clear/enable inputs, expire output), instantiated only under ARB_TIMEOUT_EN.

Test Plan:
- Reset: rst_ni low during GNT_D with bus_ack_i=1 -> no dmem_ack_o; all outputs 0; state IDLE after release.
- Simultaneous requests: imem_valid_i=1, dmem_valid_i=1 (addr 0x100, we=1, sel=4'b0010, data 0x0000AB00), bus_ack_i after 2 wait cycles:
  - bus shows dmem fields; dmem_ack_o pulses once; imem_ack_o stays 0.
  - After one IDLE cycle, bus shows imem_addr_i.
- Fetch with zero-wait slave: imem_addr_i=0x0001_0000, bus_data_i=0x0000_0013 -> imem_ack_o high on cycle 2, imem_data_o=0x13; next grant starts cycle 4.
- Abandon: GNT_I, imem_valid_i drops with no ack -> bus_valid_o drops the same cycle; next state IDLE; no ack issued.
- Stray ack: bus_ack_i=1 in IDLE -> both acks stay 0.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): GNT_D, bus_ack_i held 0 -> dmem_ack_o pulses with dmem_data_o=0xDEADBEEF on the 4th grant cycle; timeout_o=1 and remains set.
